// File: rtl/nec_bus_pkg.sv
// Shared types and widths for the NEC V30/V33 bus slave.
// The FSM state encoding and the latched request bundle live here.
package nec_bus_pkg;

    localparam int NEC_ADDR_W = 20;
    localparam int NEC_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACCESS,
        WAIT,
        DONE
    } nec_state_t;

    typedef struct packed {
        logic [NEC_ADDR_W-1:0] addr;
        logic [1:0]            be;
        logic                  we;
        logic                  io;
        logic [NEC_DATA_W-1:0] wdata;
    } nec_req_t;

    // UBEn selects the odd byte and A0 low selects the even byte
    function automatic logic [1:0] nec_byte_en(input logic uben, input logic a0);
        return {~uben, ~a0};
    endfunction

endpackage

// File: rtl/nec_clkgen.sv
// Free-running CPU clock divider with a registered 50% duty output.
// o_nec_clk_rise pulses for one clk in the cycle where o_nec_clk goes high.
module nec_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_nec_clk,
    output logic o_nec_clk_rise
);

    localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_nec_clk;
    logic             r_rise;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_nec_clk <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            if (r_cnt == '0 || r_cnt == CNT_HALF) begin
                r_nec_clk <= ~r_nec_clk;
            end
            // Count 0 always drives the low-to-high toggle
            r_rise <= (r_cnt == '0);
        end
    end

    assign o_nec_clk      = r_nec_clk;
    assign o_nec_clk_rise = r_rise;

endmodule

// File: rtl/nec_bus_ctrl.sv
// NEC V30/V33 bus slave: synchronises the CPU strobes, decodes AD-bus cycles into a
// req/ack memory/IO port, stretches READY with wait states and answers INTA cycles.
module nec_bus_ctrl
    import nec_bus_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic                  o_nec_clk,
    input  logic [NEC_ADDR_W-1:0] i_nec_ad_in,
    output logic [NEC_DATA_W-1:0] o_nec_ad_out,
    output logic                  o_nec_ad_oe,
    output logic                  o_nec_ad_dir,
    output logic                  o_nec_ready,
    input  logic                  i_nec_astb,
    input  logic                  i_nec_rdn,
    input  logic                  i_nec_wrn,
    input  logic                  i_nec_ion,
    input  logic                  i_nec_uben,
    input  logic                  i_nec_intakn,
    input  logic [7:0]            i_int_vector,
    output logic                  o_mem_req,
    input  logic                  i_mem_ack,
    output logic                  o_mem_we,
    output logic                  o_mem_io,
    output logic [NEC_ADDR_W-1:0] o_mem_addr,
    output logic [1:0]            o_mem_be,
    output logic [NEC_DATA_W-1:0] o_mem_wdata,
    input  logic [NEC_DATA_W-1:0] i_mem_rdata,
    output logic                  o_busy
);

    localparam int unsigned       SYNC_W    = NEC_ADDR_W + 6;
    // Strobes idle high, ASTB idle low
    localparam logic [SYNC_W-1:0] SYNC_RST  = {{NEC_ADDR_W{1'b0}}, 6'b011111};
    localparam logic [3:0]        LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic                  w_nec_rise;
    logic [SYNC_W-1:0]     r_sync [SYNC_STAGES];
    logic [SYNC_W-1:0]     w_pins;
    logic [NEC_ADDR_W-1:0] w_ad;
    logic                  w_astb, w_rdn, w_wrn, w_ionn, w_uben, w_intakn;
    logic                  r_astb_d;
    logic                  w_astb_fall;
    logic                  w_can_latch;

    nec_state_t            r_state, w_state_d;
    nec_req_t              r_req;
    logic [NEC_DATA_W-1:0] r_rdata;
    logic                  r_drive;
    logic [3:0]            r_wait_cnt;

    nec_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_nec_clk      (o_nec_clk),
        .o_nec_clk_rise (w_nec_rise)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= SYNC_RST;
            end
            r_astb_d <= 1'b0;
        end else begin
            r_sync[0] <= {i_nec_ad_in, i_nec_astb, i_nec_rdn, i_nec_wrn,
                          i_nec_ion, i_nec_uben, i_nec_intakn};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_astb_d <= w_astb;
        end
    end

    assign w_pins = r_sync[SYNC_STAGES-1];
    assign {w_ad, w_astb, w_rdn, w_wrn, w_ionn, w_uben, w_intakn} = w_pins;
    assign w_astb_fall = r_astb_d & ~w_astb;
    // A new address phase is refused while a memory access is outstanding
    assign w_can_latch = w_astb_fall && (r_state != ACCESS) && (r_state != WAIT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (w_can_latch) w_state_d = ADDR;
            end
            ADDR: begin
                if (w_can_latch)              w_state_d = ADDR;
                else if (!w_rdn || !w_wrn)    w_state_d = ACCESS;
                else if (!w_intakn)           w_state_d = DONE;
            end
            ACCESS: begin
                if (i_mem_ack) w_state_d = (WAIT_STATES > 0) ? WAIT : DONE;
            end
            WAIT: begin
                if (w_nec_rise && r_wait_cnt == LAST_WAIT) w_state_d = DONE;
            end
            DONE: begin
                if (w_can_latch)                       w_state_d = ADDR;
                else if (w_rdn && w_wrn && w_intakn)   w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req      <= '0;
            r_rdata    <= '0;
            r_drive    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_can_latch) begin
                r_req.addr <= w_ad;
                r_req.io   <= ~w_ionn;
                r_req.be   <= nec_byte_en(w_uben, w_ad[0]);
            end
            if (r_state == ADDR && !w_can_latch) begin
                if (!w_rdn || !w_wrn) begin
                    r_req.we <= ~w_wrn;
                    r_drive  <= w_wrn;
                    if (!w_wrn) r_req.wdata <= w_ad[NEC_DATA_W-1:0];
                end else if (!w_intakn) begin
                    r_rdata <= {8'h00, i_int_vector};
                    r_drive <= 1'b1;
                end
            end
            if (r_state == ACCESS && i_mem_ack) begin
                r_rdata    <= i_mem_rdata;
                r_wait_cnt <= '0;
            end
            if (r_state == WAIT && w_nec_rise) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        o_mem_req    = (r_state == ACCESS);
        o_nec_ready  = (r_state != ACCESS) && (r_state != WAIT);
        o_nec_ad_oe  = (r_state == DONE) && r_drive;
        o_nec_ad_dir = (r_state == DONE) && r_drive;
        o_busy       = (r_state != IDLE);
    end

    assign o_nec_ad_out = r_rdata;
    assign o_mem_we     = r_req.we;
    assign o_mem_io     = r_req.io;
    assign o_mem_addr   = r_req.addr;
    assign o_mem_be     = r_req.be;
    assign o_mem_wdata  = r_req.wdata;

endmodule

// File: tb/tb_nec_bus_ctrl.sv
// Directed bench for nec_bus_ctrl: one instance without wait states, one with three,
// both driven by the same CPU pins and memory responses.
module tb_nec_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ad_in;
    logic        astb, rdn, wrn, ionn, uben, intakn;
    logic [7:0]  int_vector;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic        d0_nec_clk, d0_oe, d0_dir, d0_ready, d0_req, d0_we, d0_io, d0_busy;
    logic [15:0] d0_ad_out, d0_wdata;
    logic [19:0] d0_addr;
    logic [1:0]  d0_be;
    logic        d3_nec_clk, d3_oe, d3_dir, d3_ready, d3_req, d3_we, d3_io, d3_busy;
    logic [15:0] d3_ad_out, d3_wdata;
    logic [19:0] d3_addr;
    logic [1:0]  d3_be;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nec_bus_ctrl #(.CLK_DIV(6), .WAIT_STATES(0), .SYNC_STAGES(2)) u_dut0 (
        .i_clk(clk), .i_reset(reset), .o_nec_clk(d0_nec_clk), .i_nec_ad_in(ad_in),
        .o_nec_ad_out(d0_ad_out), .o_nec_ad_oe(d0_oe), .o_nec_ad_dir(d0_dir),
        .o_nec_ready(d0_ready), .i_nec_astb(astb), .i_nec_rdn(rdn), .i_nec_wrn(wrn),
        .i_nec_ion(ionn), .i_nec_uben(uben), .i_nec_intakn(intakn),
        .i_int_vector(int_vector), .o_mem_req(d0_req), .i_mem_ack(mem_ack),
        .o_mem_we(d0_we), .o_mem_io(d0_io), .o_mem_addr(d0_addr), .o_mem_be(d0_be),
        .o_mem_wdata(d0_wdata), .i_mem_rdata(mem_rdata), .o_busy(d0_busy)
    );

    nec_bus_ctrl #(.CLK_DIV(6), .WAIT_STATES(3), .SYNC_STAGES(2)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .o_nec_clk(d3_nec_clk), .i_nec_ad_in(ad_in),
        .o_nec_ad_out(d3_ad_out), .o_nec_ad_oe(d3_oe), .o_nec_ad_dir(d3_dir),
        .o_nec_ready(d3_ready), .i_nec_astb(astb), .i_nec_rdn(rdn), .i_nec_wrn(wrn),
        .i_nec_ion(ionn), .i_nec_uben(uben), .i_nec_intakn(intakn),
        .i_int_vector(int_vector), .o_mem_req(d3_req), .i_mem_ack(mem_ack),
        .o_mem_we(d3_we), .o_mem_io(d3_io), .o_mem_addr(d3_addr), .o_mem_be(d3_be),
        .o_mem_wdata(d3_wdata), .i_mem_rdata(mem_rdata), .o_busy(d3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic astb_pulse(input logic [19:0] ad, input logic io_n, input logic ube_n);
        ad_in = ad;
        ionn  = io_n;
        uben  = ube_n;
        astb  = 1'b1;
        tick(3);
        astb  = 1'b0;
        tick(3);
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 30; k++) begin
            if (d0_req && d3_req) break;
            tick(1);
        end
        chk(tag, {d3_req, d0_req}, 2'b11);
    endtask

    task automatic wait_d3_ready(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (d3_ready) break;
            tick(1);
        end
        chk(tag, d3_ready, 1'b1);
    endtask

    initial begin
        logic prev;
        int   rises, hi, lo;
        logic bad;

        reset = 1'b1;
        ad_in = '0; astb = 1'b0; rdn = 1'b1; wrn = 1'b1; ionn = 1'b1; uben = 1'b1;
        intakn = 1'b1; int_vector = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(3);
        chk("rst_nec_clk", d0_nec_clk, 1'b0);
        chk("rst_ready", {d3_ready, d0_ready}, 2'b11);
        chk("rst_req_oe_busy", {d0_req, d0_oe, d0_dir, d0_busy}, 4'b0000);
        chk("rst_mem_outs", {d0_we, d0_io, d0_be, d0_addr}, 24'h0);
        chk("rst_ad_wdata", {d0_ad_out, d0_wdata}, 32'h0);

        // Clock shape
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (d0_nec_clk) break;
            tick(1);
        end
        hi = 0;
        while (d0_nec_clk && hi < 20) begin hi++; tick(1); end
        lo = 0;
        while (!d0_nec_clk && lo < 20) begin lo++; tick(1); end
        chk("clk_high_len", hi, 3);
        chk("clk_low_len", lo, 3);

        // Word read
        astb_pulse(20'h12344, 1'b1, 1'b0);
        rdn = 1'b0;
        wait_req("rd_req");
        chk("rd_addr", d0_addr, 20'h12344);
        chk("rd_be_we_io", {d0_be, d0_we, d0_io}, 4'b1100);
        chk("rd_ready_low", {d3_ready, d0_ready}, 2'b00);
        tick(5);
        chk("rd_req_held", {d0_req, d0_addr}, {1'b1, 20'h12344});
        mem_rdata = 16'hBEEF;
        mem_ack   = 1'b1;
        chk("rd_ready_at_ack", d0_ready, 1'b0);
        prev  = d3_nec_clk;
        rises = 0;
        tick(1);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        chk("rd_ready_ack1", d0_ready, 1'b1);
        chk("rd_req_drop", d0_req, 1'b0);
        chk("rd_ad_out", {d0_oe, d0_dir, d0_ad_out}, {2'b11, 16'hBEEF});
        chk("ws_ready_low", d3_ready, 1'b0);
        for (int k = 0; k < 60; k++) begin
            if (d3_nec_clk && !prev) rises++;
            prev = d3_nec_clk;
            if (d3_ready) break;
            tick(1);
        end
        chk("ws_ready_high", d3_ready, 1'b1);
        chk("ws_rises", rises, 3);
        chk("ws_ad_out", {d3_oe, d3_ad_out}, {1'b1, 16'hBEEF});
        tick(3);
        chk("rd_oe_held", d0_oe, 1'b1);
        rdn = 1'b1;
        tick(4);
        chk("rd_release", {d0_oe, d0_dir, d0_busy, d3_oe, d3_busy}, 5'b00000);

        // IO write, high byte only
        astb_pulse(20'h00081, 1'b0, 1'b0);
        ad_in = 20'h0A500;
        wrn   = 1'b0;
        wait_req("wr_req");
        chk("wr_addr", d0_addr, 20'h00081);
        chk("wr_io_be_we", {d0_io, d0_be, d0_we}, 4'b1101);
        chk("wr_wdata", d0_wdata, 16'hA500);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        chk("wr_done_no_drive", {d0_ready, d0_oe, d0_dir}, 3'b100);
        wait_d3_ready("wr_ws_ready");
        wrn  = 1'b1;
        ionn = 1'b1;
        tick(4);
        chk("wr_idle", {d0_busy, d3_busy}, 2'b00);

        // Stray ack while idle
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        tick(1);
        chk("stray_ack", {d0_busy, d0_req, d3_busy, d3_req}, 4'b0000);

        // Interrupt acknowledge
        int_vector = 8'h42;
        astb_pulse(20'h00000, 1'b1, 1'b1);
        intakn = 1'b0;
        bad    = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (d0_req || d3_req || !d0_ready || !d3_ready) bad = 1'b1;
            tick(1);
        end
        chk("inta_no_req_ready", bad, 1'b0);
        chk("inta_vec_d0", {d0_oe, d0_dir, d0_ad_out}, {2'b11, 16'h0042});
        chk("inta_vec_d3", {d3_oe, d3_ad_out}, {1'b1, 16'h0042});
        intakn = 1'b1;
        tick(4);
        chk("inta_release", {d0_oe, d0_busy}, 2'b00);

        // Reset during ACCESS
        astb_pulse(20'h50000, 1'b1, 1'b1);
        rdn = 1'b0;
        wait_req("rst_acc_req");
        chk("rst_acc_be", d0_be, 2'b01);
        reset = 1'b1;
        #1;
        chk("rst_acc_outs", {d0_req, d0_ready, d0_oe, d0_busy}, 4'b0100);
        chk("rst_acc_d3", {d3_req, d3_ready, d3_busy}, 3'b010);
        chk("rst_acc_addr", d0_addr, 20'h0);
        rdn = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        astb_pulse(20'h23456, 1'b1, 1'b0);
        rdn = 1'b0;
        wait_req("post_rst_req");
        chk("post_rst_addr", {d0_addr, d0_be, d0_we}, {20'h23456, 2'b11, 1'b0});
        mem_rdata = 16'h1234;
        mem_ack   = 1'b1;
        tick(1);
        mem_ack   = 1'b0;
        chk("post_rst_data", {d0_ready, d0_oe, d0_ad_out}, {2'b11, 16'h1234});
        wait_d3_ready("post_rst_ws");
        rdn = 1'b1;
        tick(4);
        chk("post_rst_idle", {d0_busy, d3_busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nec_bus_ctrl.md
Name: nec_bus_ctrl

Overview:
- Parametrised NEC V30/V33 bus slave. Generates the CPU clock, decodes multiplexed AD-bus cycles (ASTB/RDn/WRn/IOn/UBEn/INTAKn) and turns them into a req/ack memory/IO port.
- Controls READY with programmable wait states and answers interrupt-acknowledge cycles from a vector input.
- Sits between the emu top level NEC_* pins and the backing store (BRAM/SDRAM arbiter).
- Replaces the fixed divide-by-4 clock and the tied-off READY.

Parameters:
- CLK_DIV, 4: clk cycles per nec_clk period; even, >=2.
- WAIT_STATES, 0: extra nec_clk periods READY is held low after mem_ack; 0..15.
- SYNC_STAGES, 2: synchroniser depth on NEC inputs; >=1.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- nec_clk  out  1  CPU clock, 50% duty
- nec_ad_in  in  20  AD[19:0] sampled from the pins
- nec_ad_out  out  16  read data driven onto AD[15:0]
- nec_ad_oe  out  1  1 = drive AD[15:0]
- nec_ad_dir  out  1  transceiver direction; 1 = FPGA->CPU
- nec_ready  out  1  CPU READY
- nec_astb  in  1  address strobe
- nec_rdn, nec_wrn, nec_ion, nec_uben, nec_intakn  in  1 each  active-low CPU strobes
- int_vector  in  8  vector returned on INTA
- mem_req  out  1  access request, held until ack
- mem_ack  in  1  one-cycle completion pulse
- mem_we  out  1  1 = write
- mem_io  out  1  1 = IO space
- mem_addr  out  20  latched byte address
- mem_be  out  2  byte enables {high, low}
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- busy  out  1  1 while the FSM is not IDLE

Behaviour:
- Reset values: nec_clk=0, nec_ad_out=0, nec_ad_oe=0, nec_ad_dir=0, nec_ready=1, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_be=0, mem_wdata=0, busy=0, FSM=IDLE.
- Clock generation: counter 0..CLK_DIV-1. nec_clk toggles at count 0 and at count CLK_DIV/2. Output is registered (glitch-free) and free-running outside reset.
- Input handling: all NEC inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised copies.
- ASTB falling edge (any state except ACCESS/WAIT):
  - latch mem_addr = ad_in[19:0] and mem_io = ~ionn;
  - mem_be = {~uben, ~ad_in[0]};
  - go to ADDR.
- ADDR, RDn or WRn asserted (low):
  - mem_we = ~wrn; on a write, mem_wdata = ad_in[15:0] sampled that cycle;
  - mem_req=1, nec_ready=0, go to ACCESS.
- ADDR, INTAKn asserted: load vector {8'h00, int_vector}, skip memory and go to DONE. READY stays 1; no mem_req.
- ACCESS: hold mem_req and all mem_* outputs stable until mem_ack. On ack: mem_req=0, capture mem_rdata, go to WAIT (if WAIT_STATES>0) else DONE.
- WAIT: count WAIT_STATES nec_clk rising edges, then go to DONE.
- DONE:
  - nec_ready=1;
  - for reads/INTA: nec_ad_dir=1, nec_ad_oe=1, nec_ad_out=captured data;
  - stay until RDn, WRn and INTAKn are all deasserted, then nec_ad_oe=0, nec_ad_dir=0, return to IDLE.
- READY latency: READY rises no earlier than WAIT_STATES nec_clk periods after mem_ack. With WAIT_STATES=0 it rises 1 clk after ack.
- Boundaries:
  - ASTB during ACCESS/WAIT is a protocol error: ignored, and the current cycle completes.
  - Strobes released before ACCESS completes: the transaction still completes to memory; DONE exits immediately.
  - mem_ack outside ACCESS is ignored.
  - ASTB and RD in the same synchronised cycle: address is latched first; RD is acted on the next cycle.
  - Async reset mid-cycle: all outputs return to reset values at once. The in-flight mem_req is dropped, and the memory side must tolerate an abandoned request.
- busy = (FSM != IDLE).

Decomposition:
- Package nec_bus_pkg:
  - typedef enum {IDLE, ADDR, ACCESS, WAIT, DONE} nec_state_t;
  - struct nec_req_t {addr, be, we, io, wdata};
  - localparam NEC_ADDR_W=20, NEC_DATA_W=16.
- One sub-module, nec_clkgen: counter, nec_clk, and a one-clk nec_clk_rise strobe used by the WAIT counter.

Test Plan:
- Clock: CLK_DIV=6, after reset release -> nec_clk period 6 clk, high 3 clk, low 3 clk; no glitches.
- Memory word read: ASTB with AD=20'h1_2344, uben=0, RDn low; mem_ack with rdata=16'hBEEF after 5 clk -> mem_addr=20'h12344, be=2'b11, we=0; READY low until ack+1; AD out 16'hBEEF with oe=1 until RDn high.
- IO write with high byte only: AD=20'h0_0081, ionn=0, uben=0, WRn low with data 16'hA500 -> mem_io=1, be=2'b10, wdata=16'hA500, we=1.
- Wait states: WAIT_STATES=3 -> READY rises exactly 3 nec_clk rising edges after mem_ack.
- INTA: int_vector=8'h42, INTAKn pulse -> ad_out=16'h0042, mem_req never asserted, READY stays 1.
- Reset in ACCESS: assert reset while mem_req=1 -> mem_req=0, READY=1, oe=0 in the same cycle; next ASTB is handled normally.
